// File: rtl/tri_mode_ethernet_mac_tx.sv
`default_nettype none
// ============================================================================
// tri_mode_ethernet_mac_tx : AXI-Stream to framed-byte Ethernet transmit MAC
// Revision: 1.0
// ============================================================================
module tri_mode_ethernet_mac_tx #(
  parameter int C_MIN_FRAME = 60,
  parameter int C_MAX_FRAME = 1514,
  parameter int C_IFG       = 12
) (
  input  logic       tx_mac_aclk,
  input  logic       tx_mac_reset,
  input  logic [7:0] tx_axis_mac_tdata,
  input  logic       tx_axis_mac_tvalid,
  input  logic       tx_axis_mac_tlast,
  input  logic       tx_axis_mac_tuser,
  output logic       tx_axis_mac_tready,
  output logic [7:0] tx_axis_rgmii_tdata,
  output logic       tx_axis_rgmii_tvalid,
  input  logic       tx_axis_rgmii_tready,
  output logic       tx_frame_done,
  output logic       tx_frame_error
);

  localparam logic [11:0] c_min_frame = 12'(C_MIN_FRAME);
  localparam logic [11:0] c_max_frame = 12'(C_MAX_FRAME);
  localparam logic [8:0]  c_ifg       = 9'(C_IFG);
  localparam logic [31:0] c_crc_init  = 32'hFFFF_FFFF;
  localparam logic [31:0] c_crc_poly  = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA     = 3'd2,
    S_PAD      = 3'd3,
    S_FCS      = 3'd4,
    S_DRAIN    = 3'd5,
    S_IFG      = 3'd6
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic [2:0]  r_pre_cnt,  w_pre_cnt_nxt;
  logic [11:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [2:0]  r_fcs_cnt,  w_fcs_cnt_nxt;
  logic [7:0]  r_ifg_cnt,  w_ifg_cnt_nxt;
  logic [31:0] r_crc,      w_crc_nxt;
  logic        r_err,      w_err_nxt;
  logic        r_open,     w_open_nxt;
  logic [7:0]  r_tdata,    w_tdata_nxt;
  logic        r_tvalid,   w_tvalid_nxt;

  logic        w_adv;
  logic [11:0] w_cnt_inc;
  logic [31:0] w_fcs_val;
  logic        w_ifg_done;
  logic        w_ifg_step;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? c_crc_poly : 32'd0);
    end
    return c;
  endfunction

  assign w_adv      = !r_tvalid || tx_axis_rgmii_tready;
  assign w_cnt_inc  = r_byte_cnt + 12'd1;
  // Omitting the final complement on errored frames guarantees a bad FCS.
  assign w_fcs_val  = r_err ? r_crc : ~r_crc;
  assign w_ifg_step = tx_axis_rgmii_tready && ({1'b0, r_ifg_cnt} < c_ifg);
  assign w_ifg_done = ({1'b0, r_ifg_cnt} + {8'd0, tx_axis_rgmii_tready}) >= c_ifg;

  assign tx_axis_rgmii_tdata  = r_tdata;
  assign tx_axis_rgmii_tvalid = r_tvalid;

  always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset) begin
    if (tx_mac_reset) begin
      r_state    <= S_IDLE;
      r_pre_cnt  <= 3'd0;
      r_byte_cnt <= 12'd0;
      r_fcs_cnt  <= 3'd0;
      r_ifg_cnt  <= 8'd0;
      r_crc      <= c_crc_init;
      r_err      <= 1'b0;
      r_open     <= 1'b0;
      r_tdata    <= 8'd0;
      r_tvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pre_cnt  <= w_pre_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_fcs_cnt  <= w_fcs_cnt_nxt;
      r_ifg_cnt  <= w_ifg_cnt_nxt;
      r_crc      <= w_crc_nxt;
      r_err      <= w_err_nxt;
      r_open     <= w_open_nxt;
      r_tdata    <= w_tdata_nxt;
      r_tvalid   <= w_tvalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pre_cnt_nxt      = r_pre_cnt;
    w_byte_cnt_nxt     = r_byte_cnt;
    w_fcs_cnt_nxt      = r_fcs_cnt;
    w_ifg_cnt_nxt      = r_ifg_cnt;
    w_crc_nxt          = r_crc;
    w_err_nxt          = r_err;
    w_open_nxt         = r_open;
    w_tdata_nxt        = r_tdata;
    w_tvalid_nxt       = r_tvalid;
    tx_axis_mac_tready = 1'b0;
    tx_frame_done      = 1'b0;
    tx_frame_error     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_adv) begin
          w_tvalid_nxt = 1'b0;
          if (tx_axis_mac_tvalid) begin
            w_tdata_nxt   = 8'h55;
            w_tvalid_nxt  = 1'b1;
            w_pre_cnt_nxt = 3'd0;
            w_state_nxt   = S_PREAMBLE;
          end
        end
      end

      S_PREAMBLE: begin
        w_crc_nxt      = c_crc_init;
        w_byte_cnt_nxt = 12'd0;
        w_err_nxt      = 1'b0;
        w_open_nxt     = 1'b0;
        if (w_adv) begin
          w_tvalid_nxt = 1'b1;
          if (r_pre_cnt < 3'd6) begin
            w_tdata_nxt   = 8'h55;
            w_pre_cnt_nxt = r_pre_cnt + 3'd1;
          end else begin
            w_tdata_nxt = 8'hD5;
            w_state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        tx_axis_mac_tready = w_adv;
        w_fcs_cnt_nxt      = 3'd0;
        if (w_adv) begin
          if (tx_axis_mac_tvalid) begin
            w_tdata_nxt    = tx_axis_mac_tdata;
            w_tvalid_nxt   = 1'b1;
            w_crc_nxt      = crc32_byte(r_crc, tx_axis_mac_tdata);
            w_byte_cnt_nxt = w_cnt_inc;
            if (tx_axis_mac_tlast) begin
              w_err_nxt   = tx_axis_mac_tuser;
              w_open_nxt  = 1'b0;
              w_state_nxt = (w_cnt_inc < c_min_frame) ? S_PAD : S_FCS;
            end else if (w_cnt_inc == c_max_frame) begin
              w_err_nxt   = 1'b1;
              w_open_nxt  = 1'b1;
              w_state_nxt = S_FCS;
            end
          end else begin
            // Underrun: close the frame with a bad FCS, drop the rest later.
            w_tvalid_nxt = 1'b0;
            w_err_nxt    = 1'b1;
            w_open_nxt   = 1'b1;
            w_state_nxt  = (r_byte_cnt < c_min_frame) ? S_PAD : S_FCS;
          end
        end
      end

      S_PAD: begin
        if (w_adv) begin
          w_tdata_nxt    = 8'h00;
          w_tvalid_nxt   = 1'b1;
          w_crc_nxt      = crc32_byte(r_crc, 8'h00);
          w_byte_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= c_min_frame) begin
            w_state_nxt = S_FCS;
          end
        end
      end

      S_FCS: begin
        if (w_adv) begin
          if (r_fcs_cnt == 3'd4) begin
            // Last FCS byte is on the output and being accepted this cycle.
            tx_frame_done  = 1'b1;
            tx_frame_error = r_err;
            w_tvalid_nxt   = 1'b0;
            w_ifg_cnt_nxt  = 8'd0;
            w_state_nxt    = r_open ? S_DRAIN : S_IFG;
          end else begin
            w_tdata_nxt   = w_fcs_val[{r_fcs_cnt[1:0], 3'b000} +: 8];
            w_tvalid_nxt  = 1'b1;
            w_fcs_cnt_nxt = r_fcs_cnt + 3'd1;
          end
        end
      end

      S_DRAIN: begin
        tx_axis_mac_tready = 1'b1;
        if (w_adv) begin
          w_tvalid_nxt = 1'b0;
        end
        if (w_ifg_step) begin
          w_ifg_cnt_nxt = r_ifg_cnt + 8'd1;
        end
        if (tx_axis_mac_tvalid && tx_axis_mac_tlast) begin
          w_open_nxt  = 1'b0;
          w_state_nxt = S_IFG;
        end
      end

      S_IFG: begin
        if (w_ifg_step) begin
          w_ifg_cnt_nxt = r_ifg_cnt + 8'd1;
        end
        // The final gap slot doubles as the idle-to-preamble load cycle.
        if (w_ifg_done) begin
          if (tx_axis_mac_tvalid && w_adv) begin
            w_tdata_nxt   = 8'h55;
            w_tvalid_nxt  = 1'b1;
            w_pre_cnt_nxt = 3'd0;
            w_state_nxt   = S_PREAMBLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_mode_ethernet_mac_tx.sv
`default_nettype none
// ============================================================================
// tb_tri_mode_ethernet_mac_tx : scoreboard bench for the Ethernet TX framer
// Revision: 1.0
// ============================================================================
module tb_tri_mode_ethernet_mac_tx;

  localparam int MIN_F       = 60;
  localparam int MAX_F       = 1514;
  localparam int IFG         = 12;
  localparam int HS_BUDGET   = 500;
  localparam int DONE_BUDGET = 5000;
  localparam int NV          = 11;

  logic       clk;
  logic       rst;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       mac_tready;
  logic [7:0] rg_tdata;
  logic       rg_tvalid;
  logic       rg_tready;
  logic       done;
  logic       error;

  logic [7:0] np_tdata;
  logic       np_tvalid;
  logic       np_tlast;
  logic       np_tuser;
  logic       np_mac_tready;
  logic [7:0] np_rg_tdata;
  logic       np_rg_tvalid;
  logic       np_rg_tready;
  logic       np_done;
  logic       np_error;

  tri_mode_ethernet_mac_tx dut (
    .tx_mac_aclk          (clk),
    .tx_mac_reset         (rst),
    .tx_axis_mac_tdata    (tdata),
    .tx_axis_mac_tvalid   (tvalid),
    .tx_axis_mac_tlast    (tlast),
    .tx_axis_mac_tuser    (tuser),
    .tx_axis_mac_tready   (mac_tready),
    .tx_axis_rgmii_tdata  (rg_tdata),
    .tx_axis_rgmii_tvalid (rg_tvalid),
    .tx_axis_rgmii_tready (rg_tready),
    .tx_frame_done        (done),
    .tx_frame_error       (error)
  );

  tri_mode_ethernet_mac_tx #(.C_MIN_FRAME(0)) dut_np (
    .tx_mac_aclk          (clk),
    .tx_mac_reset         (rst),
    .tx_axis_mac_tdata    (np_tdata),
    .tx_axis_mac_tvalid   (np_tvalid),
    .tx_axis_mac_tlast    (np_tlast),
    .tx_axis_mac_tuser    (np_tuser),
    .tx_axis_mac_tready   (np_mac_tready),
    .tx_axis_rgmii_tdata  (np_rg_tdata),
    .tx_axis_rgmii_tvalid (np_rg_tvalid),
    .tx_axis_rgmii_tready (np_rg_tready),
    .tx_frame_done        (np_done),
    .tx_frame_error       (np_error)
  );

  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         err;
  } exp_t;

  typedef struct {
    int len;
    bit tu;
    bit rnd;
    int gap;
    bit reuse;
    int eb;
    bit ee;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vec[NV];
  logic [7:0] frm[0:2047];
  logic [7:0] np_exp[0:20];

  int  n_checks;
  int  n_errors;
  int  obs_bytes;
  int  frames_done;
  bit  last_err;
  bit  rnd_ready;
  bit  mon_off;

  bit         prev_stall;
  logic [7:0] prev_data;
  bit         in_gap;
  int         gap;
  bit         acc;
  exp_t       e;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  function automatic logic [31:0] ref_crc(input logic [7:0] body[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (body[k]) begin
      c = c ^ {24'd0, body[k]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return c;
  endfunction

  task automatic push_frame(input int n, input bit tu, input int gap_at);
    logic [7:0]  body[$];
    int          sent;
    bit          er;
    logic [31:0] f;
    exp_t        x;
    sent = (gap_at >= 0) ? gap_at : ((n > MAX_F) ? MAX_F : n);
    er   = (gap_at >= 0) || (n > MAX_F) || tu;
    for (int i = 0; i < sent; i++) body.push_back(frm[i]);
    while (body.size() < MIN_F) body.push_back(8'h00);
    f = ref_crc(body);
    if (!er) f = ~f;
    x.last = 1'b0;
    x.err  = er;
    for (int i = 0; i < 7; i++) begin
      x.d = 8'h55;
      exp_q.push_back(x);
    end
    x.d = 8'hD5;
    exp_q.push_back(x);
    foreach (body[k]) begin
      x.d = body[k];
      exp_q.push_back(x);
    end
    for (int i = 0; i < 4; i++) begin
      x.d    = f[8*i +: 8];
      x.last = (i == 3);
      exp_q.push_back(x);
    end
  endtask

  task automatic drive_frame(input int n, input bit tu, input int gap_at, input int stop_at);
    int cnt;
    bit hs;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) return;
      if (i == gap_at) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      tdata  = frm[i];
      tvalid = 1'b1;
      tlast  = (i == n - 1);
      tuser  = tu && (i == n - 1);
      cnt    = 0;
      hs     = 1'b0;
      while (!hs && cnt < HS_BUDGET) begin
        @(negedge clk);
        hs = mac_tready;
        @(posedge clk);
        #1;
        cnt++;
      end
      if (!hs) begin
        fail_now("handshake_timeout");
        break;
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic wait_done(input int fd0);
    int cnt;
    cnt = 0;
    while (frames_done == fd0 && cnt < DONE_BUDGET) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    if (frames_done == fd0) fail_now("frame_done_timeout");
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rg_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: stall stability, scoreboard compare, done/error, IFG length
  always @(negedge clk) begin
    if (rst || mon_off) begin
      prev_stall = 1'b0;
      in_gap     = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 32'(rg_tvalid), 32'd1);
        chk("stall_tdata", 32'(rg_tdata), 32'(prev_data));
      end
      acc = rg_tvalid && rg_tready;
      if (done && !acc) fail_now("done_without_accept");
      if (error && !done) fail_now("error_without_done");
      if (acc) begin
        if (in_gap) begin
          chk("ifg_gap_min", 32'(gap >= IFG), 32'd1);
          in_gap = 1'b0;
        end
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output_byte");
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 32'(rg_tdata), 32'(e.d));
          chk("frame_done", 32'(done), 32'(e.last));
          if (e.last) begin
            chk("frame_error", 32'(error), 32'(e.err));
            last_err = error;
            frames_done++;
            in_gap = 1'b1;
            gap    = 0;
          end
          obs_bytes++;
        end
      end else if (in_gap && rg_tready) begin
        gap++;
      end
      prev_stall = rg_tvalid && !rg_tready;
      prev_data  = rg_tdata;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int base;
    int fd0;
    int idle;
    int cnt;
    bit seen;

    n_checks = 0;   n_errors = 0;   obs_bytes = 0;  frames_done = 0;
    last_err = 0;   rnd_ready = 0;  mon_off = 0;
    rst = 1'b0;     rg_tready = 1'b1;
    tdata = 8'd0;   tvalid = 1'b0;  tlast = 1'b0;   tuser = 1'b0;
    np_tdata = 8'd0; np_tvalid = 1'b0; np_tlast = 1'b0; np_tuser = 1'b0;
    np_rg_tready = 1'b1;

    vec[0]  = '{14,   1'b0, 1'b0, -1, 1'b0, 72,   1'b0};
    vec[1]  = '{1,    1'b0, 1'b0, -1, 1'b0, 72,   1'b0};
    vec[2]  = '{60,   1'b0, 1'b0, -1, 1'b0, 72,   1'b0};
    vec[3]  = '{61,   1'b0, 1'b0, -1, 1'b0, 73,   1'b0};
    vec[4]  = '{100,  1'b0, 1'b0, -1, 1'b0, 112,  1'b0};
    vec[5]  = '{100,  1'b0, 1'b1, -1, 1'b1, 112,  1'b0};
    vec[6]  = '{64,   1'b1, 1'b0, -1, 1'b0, 76,   1'b1};
    vec[7]  = '{30,   1'b0, 1'b0, 20, 1'b0, 72,   1'b1};
    vec[8]  = '{1514, 1'b0, 1'b0, -1, 1'b0, 1526, 1'b0};
    vec[9]  = '{1520, 1'b0, 1'b0, -1, 1'b0, 1526, 1'b1};
    vec[10] = '{59,   1'b1, 1'b1, -1, 1'b0, 72,   1'b1};

    for (int i = 0; i < 7; i++) np_exp[i] = 8'h55;
    np_exp[7] = 8'hD5;
    for (int i = 0; i < 9; i++) np_exp[8 + i] = 8'h31 + 8'(i);
    np_exp[17] = 8'h26; np_exp[18] = 8'h39; np_exp[19] = 8'hF4; np_exp[20] = 8'hCB;

    #2;
    rst    = 1'b1;
    tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 32'(rg_tvalid), 32'd0);
    chk("reset_tdata", 32'(rg_tdata), 32'd0);
    chk("reset_mac_tready", 32'(mac_tready), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_np_tvalid", 32'(np_rg_tvalid), 32'd0);
    tvalid = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #1;

    // Known-answer frame on the unpadded instance, followed by a second frame
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          np_tdata  = (i < 9) ? (8'h31 + 8'(i)) : 8'hAA;
          np_tlast  = (i == 8) || (i == 9);
          np_tvalid = 1'b1;
          cnt  = 0;
          seen = 1'b0;
          while (!seen && cnt < HS_BUDGET) begin
            @(negedge clk);
            seen = np_mac_tready;
            @(posedge clk);
            #1;
            cnt++;
          end
          if (!seen) begin
            fail_now("np_handshake_timeout");
            break;
          end
        end
        np_tvalid = 1'b0;
        np_tlast  = 1'b0;
      end
      begin
        idle = 0;
        @(negedge clk);
        while (!np_rg_tvalid && idle < 50) begin
          idle++;
          @(negedge clk);
        end
        if (!np_rg_tvalid) fail_now("np_first_byte_timeout");
        for (int k = 0; k < 21; k++) begin
          chk("np_tdata", 32'(np_rg_tdata), 32'(np_exp[k]));
          chk("np_done", 32'(np_done), 32'(k == 20));
          if (k == 20) chk("np_error", 32'(np_error), 32'd0);
          @(negedge clk);
        end
        idle = 0;
        while (!np_rg_tvalid && idle < 100) begin
          idle++;
          @(negedge clk);
        end
        chk("np_ifg_cycles", 32'(idle), 32'(IFG));
        chk("np_next_preamble", 32'(np_rg_tdata), 32'h55);
      end
    join
    repeat (30) @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) begin
      rnd_ready = vec[v].rnd;
      if (!vec[v].reuse) begin
        for (int i = 0; i < vec[v].len; i++) frm[i] = 8'($urandom);
      end
      push_frame(vec[v].len, vec[v].tu, vec[v].gap);
      base = obs_bytes;
      fd0  = frames_done;
      drive_frame(vec[v].len, vec[v].tu, vec[v].gap, vec[v].len);
      wait_done(fd0);
      chk("frame_byte_count", 32'(obs_bytes - base), 32'(vec[v].eb));
      chk("frame_err_flag", 32'(last_err), 32'(vec[v].ee));
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    end
    rnd_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of the data phase
    mon_off = 1'b1;
    for (int i = 0; i < 60; i++) frm[i] = 8'($urandom);
    drive_frame(60, 1'b0, -1, 30);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 32'(rg_tvalid), 32'd0);
    chk("async_rst_tdata", 32'(rg_tdata), 32'd0);
    chk("async_rst_mac_tready", 32'(mac_tready), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_error", 32'(error), 32'd0);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    mon_off = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 60; i++) frm[i] = 8'($urandom);
    push_frame(60, 1'b0, -1);
    base = obs_bytes;
    fd0  = frames_done;
    fork
      drive_frame(60, 1'b0, -1, 60);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_first_valid", 32'(rg_tvalid), 32'd1);
        chk("post_reset_first_byte", 32'(rg_tdata), 32'h55);
      end
    join
    wait_done(fd0);
    chk("post_reset_byte_count", 32'(obs_bytes - base), 32'd72);
    chk("post_reset_err_flag", 32'(last_err), 32'd0);
    chk("post_reset_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tri_mode_ethernet_mac_tx.md
Name: tri_mode_ethernet_mac_tx

Overview:
Transmit-side MAC framer for the tri-mode Ethernet path. It accepts a user frame over AXI-Stream, starting at the destination MAC and ending at the last payload byte. It prepends the 7-byte preamble and SFD, zero-pads the frame to the minimum length, appends the CRC-32 FCS and enforces the inter-frame gap. Output is a byte stream with valid/ready toward the RGMII transmit block; that block performs nibble serialization at 10/100 Mb/s and paces this block through tx_axis_rgmii_tready.

Parameters:
C_MIN_FRAME, 60, minimum bytes from DA through pad, FCS excluded; 0 disables padding.
C_MAX_FRAME, 1514, maximum user bytes per frame before oversize abort.
C_IFG, 12, idle byte slots between FCS end and next preamble (1..255).

Ports:
tx_mac_aclk  input  1  transmit clock.
tx_mac_reset  input  1  asynchronous active-high reset.
tx_axis_mac_tdata  input  8  user frame byte.
tx_axis_mac_tvalid  input  1  user byte valid.
tx_axis_mac_tlast  input  1  last user byte of frame.
tx_axis_mac_tuser  input  1  sampled with tlast; 1 = send frame with corrupted FCS.
tx_axis_mac_tready  output  1  block accepts user byte.
tx_axis_rgmii_tdata  output  8  framed byte to RGMII block.
tx_axis_rgmii_tvalid  output  1  framed byte valid.
tx_axis_rgmii_tready  input  1  RGMII block accepts byte.
tx_frame_done  output  1  one-cycle pulse when last FCS byte is accepted.
tx_frame_error  output  1  one-cycle pulse with tx_frame_done if FCS was corrupted (tuser, underrun or oversize).

Behaviour:
- Reset: asynchronous. All outputs go to 0 and the FSM goes to S_IDLE, with the IFG counter cleared. A frame in flight is abandoned with no FCS. The next frame may start one cycle after reset deasserts.
- Output stage is a single register. Define adv = !tx_axis_rgmii_tvalid || tx_axis_rgmii_tready. The register loads only when adv is true. tdata and tvalid hold stable while tvalid=1 and tready=0.
- tx_axis_mac_tready = (state==S_DATA) && adv. In S_DRAIN it is 1 unconditionally.
- FSM:
  - S_IDLE: when tx_axis_mac_tvalid=1 and adv, load 0x55 and go to S_PREAMBLE. This is one cycle of latency from tvalid to the first output byte.
  - S_PREAMBLE: emit 6 more 0x55 bytes, then 0xD5 (SFD), then go to S_DATA.
  - S_DATA: on each adv cycle:
    - If tvalid=1, forward the byte, update the CRC and increment byte_cnt (12-bit).
    - On tlast: go to S_PAD if byte_cnt+1 < C_MIN_FRAME, else to S_FCS. Latch err = tuser.
    - If tvalid=0 on an adv cycle (underrun): set err=1 and go to S_PAD or S_FCS by the same rule, and tx_axis_mac_tready stays 0 afterwards. The remainder of that user frame is discarded in S_DRAIN after the FCS is sent.
    - If byte_cnt reaches C_MAX_FRAME without tlast: set err=1, go to S_FCS, then to S_DRAIN.
  - S_PAD: emit 0x00 bytes, each included in the CRC, until byte_cnt == C_MIN_FRAME, then go to S_FCS.
  - S_FCS: emit 4 bytes, least-significant byte first. The value is ~crc; if err=1 the value is crc, i.e. the final complement is omitted, which guarantees an FCS mismatch. On acceptance of byte 4, pulse tx_frame_done (and tx_frame_error=err), then go to S_IFG, or to S_DRAIN if the user frame is still open.
  - S_DRAIN: discard user bytes until the tlast handshake, then go to S_IFG. Only the IFG count runs concurrently.
  - S_IFG: tvalid=0 for C_IFG cycles in which tx_axis_rgmii_tready=1, then go to S_IDLE.
- CRC-32 (Ethernet): polynomial 0x04C11DB7 in reflected form (0xEDB88320), LSB-first, init 0xFFFFFFFF. Covers DA through pad; preamble and SFD are excluded. The CRC is reset in S_PREAMBLE.
- Boundaries:
  - tlast on the first data byte produces a 1-byte frame, padded.
  - tlast exactly at C_MIN_FRAME gives no pad.
  - tlast coinciding with byte C_MAX_FRAME is a normal frame with no error.
  - tready deasserted mid-preamble or mid-FCS only stalls the output; content is unchanged.
  - A frame offered during S_IFG waits, and tready stays low.

Test Plan:
- C_MIN_FRAME=0: send ASCII "123456789" (0x31..0x39), tuser=0, tx_axis_rgmii_tready=1.
  -> Output 55x7, D5, 31..39, 26 39 F4 CB; tx_frame_done pulses with tx_frame_error=0; then exactly 12 idle cycles before the next frame's preamble.
- Default parameters, 14-byte frame -> 8+14+46 zero pad+4 = 72 output bytes. The FCS matches the reference CRC computed over 60 bytes.
- Random tx_axis_rgmii_tready (50%) on a 100-byte frame -> the output stream is byte-identical to the tready=1 run, and tdata is never changed while stalled.
- tuser=1 with tlast on a 64-byte frame -> FCS bytes equal the complement of the good FCS; tx_frame_error=1 with tx_frame_done.
- tvalid dropped after 20 user bytes, remaining 10 bytes plus tlast sent later -> 20 data bytes, 40 pad bytes, corrupted FCS, error pulse. The late 10 bytes are drained and not transmitted. The next frame starts only after the IFG.
- Reset asserted during the S_DATA byte 30 -> all outputs 0 asynchronously. After release, a fresh 60-byte frame is transmitted correctly with no IFG wait.
